// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter
// Placed in front of the ID remapper. It limits how many write and read
// transactions can be in flight at once, so the remapper table never
// overflows. AW/AR are gated by two saturating up/down counters. All other
// channels pass straight through with no added logic.

module axi_txn_limiter #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8,
    parameter int unsigned MAX_WR_TXNS    = 4,
    parameter int unsigned MAX_RD_TXNS    = 4,
    localparam int unsigned WR_CNT_W      = $clog2(MAX_WR_TXNS + 1),
    localparam int unsigned RD_CNT_W      = $clog2(MAX_RD_TXNS + 1),
    localparam int unsigned STRB_W        = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    // Upstream AW
    input  logic [AXI_ID_WIDTH-1:0]   in_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0] in_aw_addr,
    input  logic [7:0]                in_aw_len,
    input  logic [2:0]                in_aw_size,
    input  logic [1:0]                in_aw_burst,
    input  logic                      in_aw_lock,
    input  logic [3:0]                in_aw_cache,
    input  logic [2:0]                in_aw_prot,
    input  logic [3:0]                in_aw_qos,
    input  logic [3:0]                in_aw_region,
    input  logic [5:0]                in_aw_atop,
    input  logic [AXI_USER_WIDTH-1:0] in_aw_user,
    input  logic                      in_aw_valid,
    output logic                      in_aw_ready,

    // Upstream W
    input  logic [AXI_DATA_WIDTH-1:0] in_w_data,
    input  logic [STRB_W-1:0]         in_w_strb,
    input  logic                      in_w_last,
    input  logic [AXI_USER_WIDTH-1:0] in_w_user,
    input  logic                      in_w_valid,
    output logic                      in_w_ready,

    // Upstream B
    output logic [AXI_ID_WIDTH-1:0]   in_b_id,
    output logic [1:0]                in_b_resp,
    output logic [AXI_USER_WIDTH-1:0] in_b_user,
    output logic                      in_b_valid,
    input  logic                      in_b_ready,

    // Upstream AR
    input  logic [AXI_ID_WIDTH-1:0]   in_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0] in_ar_addr,
    input  logic [7:0]                in_ar_len,
    input  logic [2:0]                in_ar_size,
    input  logic [1:0]                in_ar_burst,
    input  logic                      in_ar_lock,
    input  logic [3:0]                in_ar_cache,
    input  logic [2:0]                in_ar_prot,
    input  logic [3:0]                in_ar_qos,
    input  logic [3:0]                in_ar_region,
    input  logic [AXI_USER_WIDTH-1:0] in_ar_user,
    input  logic                      in_ar_valid,
    output logic                      in_ar_ready,

    // Upstream R
    output logic [AXI_ID_WIDTH-1:0]   in_r_id,
    output logic [AXI_DATA_WIDTH-1:0] in_r_data,
    output logic [1:0]                in_r_resp,
    output logic                      in_r_last,
    output logic [AXI_USER_WIDTH-1:0] in_r_user,
    output logic                      in_r_valid,
    input  logic                      in_r_ready,

    // Downstream AW
    output logic [AXI_ID_WIDTH-1:0]   out_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0] out_aw_addr,
    output logic [7:0]                out_aw_len,
    output logic [2:0]                out_aw_size,
    output logic [1:0]                out_aw_burst,
    output logic                      out_aw_lock,
    output logic [3:0]                out_aw_cache,
    output logic [2:0]                out_aw_prot,
    output logic [3:0]                out_aw_qos,
    output logic [3:0]                out_aw_region,
    output logic [5:0]                out_aw_atop,
    output logic [AXI_USER_WIDTH-1:0] out_aw_user,
    output logic                      out_aw_valid,
    input  logic                      out_aw_ready,

    // Downstream W
    output logic [AXI_DATA_WIDTH-1:0] out_w_data,
    output logic [STRB_W-1:0]         out_w_strb,
    output logic                      out_w_last,
    output logic [AXI_USER_WIDTH-1:0] out_w_user,
    output logic                      out_w_valid,
    input  logic                      out_w_ready,

    // Downstream B
    input  logic [AXI_ID_WIDTH-1:0]   out_b_id,
    input  logic [1:0]                out_b_resp,
    input  logic [AXI_USER_WIDTH-1:0] out_b_user,
    input  logic                      out_b_valid,
    output logic                      out_b_ready,

    // Downstream AR
    output logic [AXI_ID_WIDTH-1:0]   out_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] out_ar_addr,
    output logic [7:0]                out_ar_len,
    output logic [2:0]                out_ar_size,
    output logic [1:0]                out_ar_burst,
    output logic                      out_ar_lock,
    output logic [3:0]                out_ar_cache,
    output logic [2:0]                out_ar_prot,
    output logic [3:0]                out_ar_qos,
    output logic [3:0]                out_ar_region,
    output logic [AXI_USER_WIDTH-1:0] out_ar_user,
    output logic                      out_ar_valid,
    input  logic                      out_ar_ready,

    // Downstream R
    input  logic [AXI_ID_WIDTH-1:0]   out_r_id,
    input  logic [AXI_DATA_WIDTH-1:0] out_r_data,
    input  logic [1:0]                out_r_resp,
    input  logic                      out_r_last,
    input  logic [AXI_USER_WIDTH-1:0] out_r_user,
    input  logic                      out_r_valid,
    output logic                      out_r_ready,

    // Status
    output logic [WR_CNT_W-1:0]       wr_cnt_o,
    output logic [RD_CNT_W-1:0]       rd_cnt_o,
    output logic                      wr_full_o,
    output logic                      rd_full_o,
    output logic                      err_o
);

    localparam logic [WR_CNT_W-1:0] WR_MAX = WR_CNT_W'(MAX_WR_TXNS);
    localparam logic [RD_CNT_W-1:0] RD_MAX = RD_CNT_W'(MAX_RD_TXNS);

    logic [WR_CNT_W-1:0] r_wrCnt;
    logic [RD_CNT_W-1:0] r_rdCnt;
    logic                r_err;

    logic [WR_CNT_W-1:0] w_wrCnt;
    logic [RD_CNT_W-1:0] w_rdCnt;
    logic                w_wrOpen;
    logic                w_rdOpen;
    logic                w_awValid;
    logic                w_arValid;
    logic                w_wrInc;
    logic                w_wrDec;
    logic                w_rdInc;
    logic                w_rdDec;
    logic                w_wrUnderflow;
    logic                w_rdUnderflow;

    // The counters only settle at the first clock edge in reset. Forcing
    // them to zero while rst_ni is low means the gates and the status
    // outputs show the reset state straight away.
    assign w_wrCnt = rst_ni ? r_wrCnt : '0;
    assign w_rdCnt = rst_ni ? r_rdCnt : '0;

    // The gates use only registered state. A gate can only close on one of
    // our own handshakes, so a pending valid is never withdrawn.
    assign w_wrOpen = (w_wrCnt < WR_MAX);
    assign w_rdOpen = (w_rdCnt < RD_MAX);

    // AW channel: gated handshake, payload unchanged
    assign w_awValid     = in_aw_valid & w_wrOpen;
    assign out_aw_valid  = w_awValid;
    assign in_aw_ready   = out_aw_ready & w_wrOpen;
    assign out_aw_id     = in_aw_id;
    assign out_aw_addr   = in_aw_addr;
    assign out_aw_len    = in_aw_len;
    assign out_aw_size   = in_aw_size;
    assign out_aw_burst  = in_aw_burst;
    assign out_aw_lock   = in_aw_lock;
    assign out_aw_cache  = in_aw_cache;
    assign out_aw_prot   = in_aw_prot;
    assign out_aw_qos    = in_aw_qos;
    assign out_aw_region = in_aw_region;
    assign out_aw_atop   = in_aw_atop;
    assign out_aw_user   = in_aw_user;

    // W channel: pure pass-through. W may arrive before its AW.
    assign out_w_data  = in_w_data;
    assign out_w_strb  = in_w_strb;
    assign out_w_last  = in_w_last;
    assign out_w_user  = in_w_user;
    assign out_w_valid = in_w_valid;
    assign in_w_ready  = out_w_ready;

    // B channel: pure pass-through
    assign in_b_id     = out_b_id;
    assign in_b_resp   = out_b_resp;
    assign in_b_user   = out_b_user;
    assign in_b_valid  = out_b_valid;
    assign out_b_ready = in_b_ready;

    // AR channel: gated handshake, payload unchanged
    assign w_arValid     = in_ar_valid & w_rdOpen;
    assign out_ar_valid  = w_arValid;
    assign in_ar_ready   = out_ar_ready & w_rdOpen;
    assign out_ar_id     = in_ar_id;
    assign out_ar_addr   = in_ar_addr;
    assign out_ar_len    = in_ar_len;
    assign out_ar_size   = in_ar_size;
    assign out_ar_burst  = in_ar_burst;
    assign out_ar_lock   = in_ar_lock;
    assign out_ar_cache  = in_ar_cache;
    assign out_ar_prot   = in_ar_prot;
    assign out_ar_qos    = in_ar_qos;
    assign out_ar_region = in_ar_region;
    assign out_ar_user   = in_ar_user;

    // R channel: pure pass-through
    assign in_r_id     = out_r_id;
    assign in_r_data   = out_r_data;
    assign in_r_resp   = out_r_resp;
    assign in_r_last   = out_r_last;
    assign in_r_user   = out_r_user;
    assign in_r_valid  = out_r_valid;
    assign out_r_ready = in_r_ready;

    // A transaction starts on an AW/AR handshake. It ends on a B handshake
    // or on the R handshake that carries r_last.
    assign w_wrInc = w_awValid & out_aw_ready;
    assign w_wrDec = out_b_valid & in_b_ready;
    assign w_rdInc = w_arValid & out_ar_ready;
    assign w_rdDec = out_r_valid & in_r_ready & out_r_last;

    // A response with nothing outstanding is a protocol error. This holds
    // even if a new request is accepted in the same cycle.
    assign w_wrUnderflow = w_wrDec & (r_wrCnt == '0);
    assign w_rdUnderflow = w_rdDec & (r_rdCnt == '0);

    // Outstanding write counter: +1 on AW, -1 on B, saturates at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wrCnt <= '0;
        end else if (w_wrInc && !w_wrDec) begin
            r_wrCnt <= r_wrCnt + WR_CNT_W'(1);
        end else if (w_wrDec && !w_wrInc && (r_wrCnt != '0)) begin
            r_wrCnt <= r_wrCnt - WR_CNT_W'(1);
        end
    end

    // Outstanding read counter: +1 on AR, -1 on the last R beat, saturates at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rdCnt <= '0;
        end else if (w_rdInc && !w_rdDec) begin
            r_rdCnt <= r_rdCnt + RD_CNT_W'(1);
        end else if (w_rdDec && !w_rdInc && (r_rdCnt != '0)) begin
            r_rdCnt <= r_rdCnt - RD_CNT_W'(1);
        end
    end

    // Sticky error flag; only reset clears it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_wrUnderflow || w_rdUnderflow) begin
            r_err <= 1'b1;
        end
    end

    assign wr_cnt_o  = w_wrCnt;
    assign rd_cnt_o  = w_rdCnt;
    assign wr_full_o = (w_wrCnt == WR_MAX);
    assign rd_full_o = (w_rdCnt == RD_MAX);
    assign err_o     = rst_ni & r_err;

endmodule

// File: doc/axi_txn_limiter.md
Name: axi_txn_limiter

Overview:
- Sits directly upstream of the ID remapper, between the master and the remapper's `in` port.
- Bounds the number of in-flight write and read transactions so that the remapper's table, sized TABLE_SIZE, is never oversubscribed.
- Counts AW/AR handshakes against completing B / last-R handshakes and gates AW/AR valid/ready when a limit is reached.
- All other channels pass through combinationally; sticky occupancy and error status is exported.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of both ports.
- AXI_DATA_WIDTH, 32, data width of both ports.
- AXI_ID_WIDTH, 8, ID width of both ports; IDs are not modified.
- AXI_USER_WIDTH, 8, user width of both ports.
- MAX_WR_TXNS, 4, maximum outstanding writes (AW accepted, B not yet accepted); must be ≥1.
- MAX_RD_TXNS, 4, maximum outstanding reads (AR accepted, last R not yet accepted); must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset, sampled on rising edge of clk_i.
- in  AXI_BUS slave  parameterised  upstream master side.
- out  AXI_BUS master  parameterised  downstream side (feeds axi_id_remap `in`).
- wr_cnt_o  out  $clog2(MAX_WR_TXNS+1)  current outstanding writes.
- rd_cnt_o  out  $clog2(MAX_RD_TXNS+1)  current outstanding reads.
- wr_full_o  out  1  wr_cnt_o == MAX_WR_TXNS.
- rd_full_o  out  1  rd_cnt_o == MAX_RD_TXNS.
- err_o  out  1  sticky protocol error: B or last-R handshake while the matching counter is 0.

Behaviour:
- Reset: on a rising edge with rst_ni=0, wr_cnt=0, rd_cnt=0, err=0. Reset mid-transaction discards all counts; no flush of in-flight bursts.
- Outputs while in reset:
  - wr_cnt_o=0, rd_cnt_o=0, err_o=0, wr_full_o=0, rd_full_o=0.
  - Channel signals follow the combinational rules below using the zeroed counters.
- Pass-through, zero latency, all fields unchanged:
  - W: in→out.
  - B: out→in.
  - R: out→in.
  - Ready signals pass through in the opposite direction.
- AW gate: wr_open = (wr_cnt < MAX_WR_TXNS).
  - out.aw_valid = in.aw_valid & wr_open.
  - in.aw_ready = out.aw_ready & wr_open.
  - All AW payload fields are passed unchanged.
- AR gate: the same rule with rd_open = (rd_cnt < MAX_RD_TXNS).
- Gates depend only on registered counters; no combinational valid→ready or ready→valid path is added.
- Valid stability: a gate can only close via an AW/AR handshake of this block, so AXI valid persistence toward out is preserved.
- Write counter per cycle:
  - inc_w = out.aw_valid & out.aw_ready.
  - dec_w = in.b_valid & in.b_ready.
  - inc & dec in the same cycle: count unchanged.
  - Only inc: +1. Only dec: -1.
- Read counter: inc_r = AR handshake; dec_r = R handshake with r_last=1. Non-last R beats do not change the count.
- Boundaries:
  - Count at MAX: inc is impossible because the gate is closed. A simultaneous dec at MAX reopens the gate on the next cycle, not the same cycle.
  - Count at 0 with dec and no inc: counter holds at 0 (saturates) and err is set to 1.
  - Count at 0 with simultaneous inc and dec: count stays 0 and err is set.
- err_o is sticky and cleared only by reset.
- W beats are not tied to AW acceptance. W may run ahead of AW, as AXI permits; the downstream block handles this.
- No internal FSM beyond the two saturating up/down counters plus the error flag. Expected size is about 150 RTL lines, including the counter logic and the interface assigns.

Test Plan:
1. Reset: hold rst_ni=0 for 3 cycles with in.aw_valid=1 → wr_cnt_o=0, err_o=0, and out.aw_valid=1 from the first cycle.
2. Write limit (MAX_WR_TXNS=2):
   - Stimulus: issue 3 AWs (IDs 5, 6, 7) with the slave always ready and B withheld.
   - Expected: first two handshake; wr_cnt_o=2; wr_full_o=1; out.aw_valid=0 and in.aw_ready=0 for ID 7.
   - Then send B id=5: wr_cnt_o=1 on the next cycle, and the ID 7 AW handshakes on the cycle after.
3. Simultaneous events: wr_cnt=1; AW handshake and B handshake in the same cycle → wr_cnt_o stays 1; err_o=0.
4. Read bursts (MAX_RD_TXNS=2):
   - Stimulus: 2 ARs with len=3; the slave returns 4 R beats for the first burst.
   - Expected: rd_cnt_o stays 2 for beats 1–3 and drops to 1 only after the r_last beat; a third AR is blocked until then.
5. Underflow: with wr_cnt=0, inject a B handshake → wr_cnt_o=0 and err_o=1; err_o stays 1 after further traffic until rst_ni=0.
6. Pass-through:
   - Stimulus: 4 AW+W with w_data=0xcafebabe and random addr/ID.
   - Expected: out fields bit-identical to in; W and B see zero-cycle latency; 4 B responses return with their original IDs in any order; final wr_cnt_o=0.
